// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and the
// in-flight tag that follows each accepted request down the pipeline.
package operationList;

    // Arbiter sequencing states: normal granting, waiting for the pipeline
    // to empty, and parked with the pipeline empty.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } mem_arb_state_t;

    // Lane index width in the tag covers the largest supported lane count (4).
    localparam int MEM_ARB_LANE_W = 2;

    // One pipeline slot: which lane issued it, whether it was a store, and
    // whether it was rejected before reaching memory.
    typedef struct packed {
        logic                      valid;
        logic [MEM_ARB_LANE_W-1:0] lane;
        logic                      we;
        logic                      err;
    } mem_arb_tag_t;

    localparam mem_arb_tag_t MEM_ARB_TAG_IDLE = '0;

    // A word access is misaligned when either of the two low address bits is set.
    function automatic logic mem_arb_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector. Starting just after the lane named by
// last_i, it picks the first lane with its valid bit set and reports the
// result both one-hot and as an encoded index. With nothing valid the grant
// is all-zero and the index is 0.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);

    // Walk last+1, last+2, ... (mod N_REQ) and stop at the first requester.
    always_comb begin : search
        int cand;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_i) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && valid_i[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant_o[cand[IDX_W-1:0]] = 1'b1;
                idx_o                    = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data memory between N_REQ lanes.
// Pipeline: grant (cycle N) -> registered memory command (N+1) ->
// memory read data (N+2) -> registered response to the lane (N+3).
// A flush request stops granting, lets in-flight traffic finish and then
// parks in HALT with flush_done high until flush drops.
// Optional build macro MEM_ARB_ALIGN_CHECK_EN: misaligned word addresses are
// granted but never reach memory and are answered with rsp_err=1.
module mem_arbiter
    import operationList::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    input  logic                     flush,
    output logic                     flush_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Per-lane views of the flattened request buses.
    logic [ADDR_W-1:0] lane_addr  [N_REQ];
    logic [DATA_W-1:0] lane_wdata [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign lane_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    mem_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              grant_en;
    logic              hs;
    logic              in_flight;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_err;

    mem_arb_tag_t      cmd_tag_q, cmd_tag_d;
    mem_arb_tag_t      rsp_tag_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Grants only while running and not being asked to flush; the rst_n term
    // keeps ready low for the whole time reset is held.
    always_comb begin
        grant_en  = rst_n && (state_q == RUN) && !flush;
        req_ready = grant_en ? pick_grant : '0;
        hs        = |(req_valid & req_ready);
        sel_addr  = lane_addr[pick_idx];
        sel_wdata = lane_wdata[pick_idx];
        sel_we    = req_we[pick_idx];
`ifdef MEM_ARB_ALIGN_CHECK_EN
        sel_err   = mem_arb_misaligned(sel_addr[1:0]);
`else
        sel_err   = 1'b0;
`endif
        last_d    = hs ? pick_idx : last_q;
        in_flight = cmd_tag_q.valid || rsp_tag_q.valid;
    end

    // FSM next state: RUN -> DRAIN on flush, DRAIN -> HALT once empty,
    // HALT -> RUN when flush is released.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush)      state_d = DRAIN;
            DRAIN:   if (!in_flight) state_d = HALT;
            HALT:    if (!flush)     state_d = RUN;
            default:                 state_d = RUN;
        endcase
    end

    // Next values for the command stage and the lane response stage.
    always_comb begin
        cmd_tag_d   = MEM_ARB_TAG_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        if (hs) begin
            cmd_tag_d.valid = 1'b1;
            cmd_tag_d.lane  = MEM_ARB_LANE_W'(pick_idx);
            cmd_tag_d.we    = sel_we;
            cmd_tag_d.err   = sel_err;
            mem_addr_d      = sel_addr;
            mem_wdata_d     = sel_wdata;
            mem_we_d        = sel_we && !sel_err;
            mem_re_d        = !sel_we && !sel_err;
        end

        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        if (rsp_tag_q.valid) begin
            rsp_valid_d[rsp_tag_q.lane[IDX_W-1:0]] = 1'b1;
            rsp_err_d = rsp_tag_q.err;
            if (!rsp_tag_q.we && !rsp_tag_q.err) begin
                rsp_data_d = mem_rdata;
            end
        end
    end

    // State, pointer and pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            last_q      <= IDX_W'(N_REQ - 1);
            cmd_tag_q   <= MEM_ARB_TAG_IDLE;
            rsp_tag_q   <= MEM_ARB_TAG_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cmd_tag_q   <= cmd_tag_d;
            rsp_tag_q   <= cmd_tag_q;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign flush_done = (state_q == HALT);

endmodule
